// File: rtl/cache_mem_pkg.sv
// Shared encodings and defaults for the I/D cache memory arbiter.
// Imported by the arbiter, its latency counter and its bus interface.
package cache_mem_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int MEM_LATENCY_DEF = 2;
  localparam int STARVE_MAX_DEF  = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side request/ack bundle plus the single memory port.
// slave = arbiter view, master = cache/memory environment view.
interface cache_mem_arbiter_if
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic [1:0]        owner;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output i_rdata, i_ack,
    output d_rdata, d_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  i_rdata, i_ack,
    input  d_rdata, d_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );

endinterface

// File: rtl/mem_lat_counter.sv
// Memory latency down-counter: loaded with LAT, counts to zero.
// last is high in the final wait cycle.
module mem_lat_counter
  import cache_mem_pkg::*;
#(
  parameter int LAT = MEM_LATENCY_DEF,
  localparam int CW = $clog2(LAT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(LAT);
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I and D caches.
// D has priority; I is forced through after STARVE_MAX D grants.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int STARVE_MAX  = STARVE_MAX_DEF
) (
  input logic                clk,
  input logic                rst,
  cache_mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              starved;
  logic              grant_i;
  logic              cnt_last;

  assign starved = (starve_q == SW'(STARVE_MAX));
  assign grant_i = bus.i_req & (~bus.d_req | starved);

  mem_lat_counter #(
    .LAT (MEM_LATENCY)
  ) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == S_ISSUE),
    .en   (state_q == S_WAIT),
    .last (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_req | bus.d_req) begin
          state_d = S_ISSUE;
          if (grant_i) begin
            owner_d  = OWN_I;
            we_d     = 1'b0;
            addr_d   = bus.i_addr;
            starve_d = '0;
          end else begin
            owner_d = OWN_D;
            we_d    = bus.d_we;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            if (!bus.i_req) starve_d = '0;
            else if (!starved) starve_d = starve_q + 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_last) begin
          state_d = S_RESP;
          // reads only; a write never disturbs the owner's rdata
          if (!we_q) begin
            if (owner_q == OWN_I) i_rdata_d = bus.mem_rdata;
            else                  d_rdata_d = bus.mem_rdata;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_NONE;
      starve_q  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.mem_en    = (state_q == S_ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ack     = (state_q == S_RESP) && (owner_q == OWN_I);
  assign bus.d_ack     = (state_q == S_RESP) && (owner_q == OWN_D);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: transaction-level model, directed + random.
// Second instance covers the single-cycle memory latency case.
module tb_cache_mem_arbiter;

  localparam int L0   = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  cache_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L0), .STARVE_MAX(SMAX)
  ) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );

  cache_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_MAX(SMAX)
  ) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // memory devices: sample on the mem_en edge, data valid LAT edges later
  logic [31:0] m0 [0:255];
  bit          v0 [0:255];
  logic [31:0] p0 [0:L0];
  logic [31:0] p1 [0:1];
  int          men1_cnt = 0;

  assign b0.mem_rdata = p0[L0];
  assign b1.mem_rdata = p1[1];

  always @(posedge clk) begin
    if (b0.mem_en && b0.mem_we) begin
      m0[b0.mem_addr[7:0]] <= b0.mem_wdata;
      v0[b0.mem_addr[7:0]] <= 1'b1;
    end
    if (b0.mem_en && !b0.mem_we)
      p0[0] <= v0[b0.mem_addr[7:0]] ? m0[b0.mem_addr[7:0]]
                                    : init_val(b0.mem_addr[7:0]);
    else
      p0[0] <= $urandom;
    for (int k = 1; k <= L0; k++) p0[k] <= p0[k-1];
  end

  always @(posedge clk) begin
    if (b1.mem_en && !b1.mem_we) p1[0] <= init_val(b1.mem_addr[7:0]);
    else                         p1[0] <= $urandom;
    p1[1] <= p1[0];
    if (b1.mem_en) men1_cnt <= men1_cnt + 1;
  end

  // reference model state
  logic [31:0] ref_mem [int];
  bit          ip, dp, dwe;
  logic [31:0] ia, da, dw;
  int          starve = 0;
  logic [31:0] exp_ir = 0, exp_dr = 0;
  bit          glog [$];

  function automatic logic [31:0] rd_ref(input logic [7:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_i(input logic [31:0] a);
    ip = 1'b1; ia = a;
    b0.i_req = 1'b1; b0.i_addr = a;
  endtask

  task automatic set_d(input bit w, input logic [31:0] a,
                       input logic [31:0] dat);
    dp = 1'b1; dwe = w; da = a; dw = dat;
    b0.d_req = 1'b1; b0.d_we = w; b0.d_addr = a; b0.d_wdata = dat;
  endtask

  task automatic rand_d();
    set_d(bit'($urandom_range(0, 1)),
          32'h40 + 32'($urandom_range(0, 191)), $urandom);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // one arbitration round, entered and left at a negedge in IDLE
  task automatic txn(input bit keep_d);
    bit          gi, w;
    logic [31:0] a, expd, wd;
    chk("idle_busy", 32'(b0.busy), 32'd0);
    chk("idle_owner", 32'(b0.owner), 32'd0);
    if (!ip && !dp) begin
      cyc();
      return;
    end
    gi = ip && (!dp || starve == SMAX);
    if (gi || !ip) starve = 0;
    else if (starve < SMAX) starve++;
    a  = gi ? ia : da;
    w  = gi ? 1'b0 : dwe;
    wd = dw;
    if (w) ref_mem[int'(a[7:0])] = wd;
    expd = rd_ref(a[7:0]);
    glog.push_back(gi);
    cyc();
    chk("issue_en", 32'(b0.mem_en), 32'd1);
    chk("issue_addr", b0.mem_addr, a);
    chk("issue_we", 32'(b0.mem_we), 32'(w));
    if (w) chk("issue_wdata", b0.mem_wdata, wd);
    chk("issue_owner", 32'(b0.owner), gi ? 32'd1 : 32'd2);
    chk("issue_busy", 32'(b0.busy), 32'd1);
    if ($urandom_range(0, 3) == 0) begin
      if (gi) begin
        b0.i_addr = $urandom; b0.i_req = 1'b0; ip = 1'b0;
      end else if (!keep_d) begin
        b0.d_addr = $urandom; b0.d_we = ~b0.d_we;
        b0.d_wdata = $urandom; b0.d_req = 1'b0; dp = 1'b0;
      end
    end
    for (int k = 1; k <= L0 + 1; k++) begin
      cyc();
      chk("wait_quiet", 32'({b0.mem_en, b0.i_ack, b0.d_ack}), 32'd0);
    end
    cyc();
    chk("resp_ack", 32'({b0.i_ack, b0.d_ack}), gi ? 32'd2 : 32'd1);
    if (!w) begin
      if (gi) exp_ir = expd;
      else    exp_dr = expd;
    end
    chk("resp_i_rdata", b0.i_rdata, exp_ir);
    chk("resp_d_rdata", b0.d_rdata, exp_dr);
    chk("resp_addr_held", b0.mem_addr, a);
    if (gi) begin
      ip = 1'b0; b0.i_req = 1'b0;
    end else if (keep_d) begin
      rand_d();
    end else begin
      dp = 1'b0; b0.d_req = 1'b0;
    end
    cyc();
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    ip = 1'b0; dp = 1'b0; dwe = 1'b0; ia = '0; da = '0; dw = '0;
    b0.i_req = 1'b0; b0.i_addr = '0;
    b0.d_req = 1'b0; b0.d_we = 1'b0; b0.d_addr = '0; b0.d_wdata = '0;
    b1.i_req = 1'b0; b1.i_addr = '0;
    b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(b0.busy), 32'd0);
    chk("rst_owner", 32'(b0.owner), 32'd0);
    chk("rst_mem", 32'({b0.mem_en, b0.mem_we, b0.i_ack, b0.d_ack}), 32'd0);
    chk("rst_addr", b0.mem_addr, 32'd0);
    chk("rst_i_rdata", b0.i_rdata, 32'd0);
    chk("rst_d_rdata", b0.d_rdata, 32'd0);
    rst = 1'b0;
    cyc();

    // basic I read
    set_i(32'h10);
    txn(1'b0);
    chk("i_read_10", b0.i_rdata, 32'hDEADBEEF);

    // D write then D read
    set_d(1'b1, 32'h20, 32'h12345678);
    txn(1'b0);
    chk("d_write_no_rdata", b0.d_rdata, 32'd0);
    set_d(1'b0, 32'h20, 32'h0);
    txn(1'b0);
    chk("d_read_20", b0.d_rdata, 32'h12345678);

    // simultaneous requests: D first
    glog.delete();
    set_i(32'h30);
    set_d(1'b0, 32'h40, 32'h0);
    txn(1'b0);
    txn(1'b0);
    chk("sim_first_d", 32'(glog[0]), 32'd0);
    chk("sim_second_i", 32'(glog[1]), 32'd1);

    // starvation: D held continuously
    glog.delete();
    set_i(32'h11);
    rand_d();
    for (int n = 0; n < 6; n++) txn(1'b1);
    for (int n = 0; n < 6; n++)
      chk("starve_seq", 32'(glog[n]), (n == 4) ? 32'd1 : 32'd0);
    dp = 1'b0; b0.d_req = 1'b0;

    // reset in WAIT
    set_i(32'h10);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("wrst_busy", 32'(b0.busy), 32'd0);
    chk("wrst_en", 32'(b0.mem_en), 32'd0);
    chk("wrst_owner", 32'(b0.owner), 32'd0);
    chk("wrst_addr", b0.mem_addr, 32'd0);
    ip = 1'b0; b0.i_req = 1'b0;
    starve = 0; exp_ir = 0; exp_dr = 0;
    repeat (3) begin
      cyc();
      chk("wrst_noack", 32'({b0.i_ack, b0.d_ack, b0.busy}), 32'd0);
    end
    rst = 1'b0;
    cyc();
    set_i(32'h10);
    txn(1'b0);
    chk("post_rst_i_read", b0.i_rdata, 32'hDEADBEEF);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      if (!ip && $urandom_range(0, 1) == 1)
        set_i(32'($urandom_range(0, 255)));
      if (!dp && $urandom_range(0, 2) != 0) rand_d();
      txn(1'b0);
    end
    ip = 1'b0; b0.i_req = 1'b0;
    dp = 1'b0; b0.d_req = 1'b0;

    // MEM_LATENCY = 1 instance
    c0 = men1_cnt;
    b1.i_req = 1'b1; b1.i_addr = 32'h10;
    cyc();
    chk("l1_issue_en", 32'(b1.mem_en), 32'd1);
    for (int k = 1; k <= 2; k++) begin
      cyc();
      chk("l1_no_ack", 32'(b1.i_ack), 32'd0);
    end
    cyc();
    chk("l1_ack", 32'(b1.i_ack), 32'd1);
    chk("l1_rdata", b1.i_rdata, 32'hDEADBEEF);
    b1.i_req = 1'b0;
    cyc();
    chk("l1_ack_drop", 32'({b1.i_ack, b1.busy}), 32'd0);
    cyc();
    chk("l1_en_pulses", 32'(men1_cnt - c0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
